i2s_sample_rx: RTL and testbench

Serial audio receiver that sits directly upstream of the lowpass FIR stage. It oversamples an I2S-format link (bclk, lrclk, sdata) in the system clock domain and deserialises each channel word MSB-first into an 18-bit two's-complement sample. Once per stereo frame it presents the left and right samples together with a single-cycle data-valid strobe, which drives the filter's sample-input and strobe inputs directly.

---
 rtl/i2s_sample_rx_if.sv | 22 ++
 rtl/i2s_sample_rx.sv | 176 +++++++++++++++++
 tb/tb_i2s_sample_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_sample_rx_if.sv
// I2S receiver bus bundle: serial link inputs and the parallel sample/strobe outputs.
interface i2s_sample_rx_if #(
    parameter int unsigned WORD_BITS = 18
);
    logic                 bclk_in;
    logic                 lrclk_in;
    logic                 sdata_in;
    logic [WORD_BITS-1:0] dataout_l;
    logic [WORD_BITS-1:0] dataout_r;
    logic                 endata;
    logic                 frame_err;

    modport master (
        output bclk_in, lrclk_in, sdata_in,
        input  dataout_l, dataout_r, endata, frame_err
    );

    modport slave (
        input  bclk_in, lrclk_in, sdata_in,
        output dataout_l, dataout_r, endata, frame_err
    );
endinterface

// File: rtl/i2s_sample_rx.sv
// Oversampling I2S receiver: deserialises left/right words and strobes each stereo pair.
// Define I2S_MONO_MIX_EN to output (L + R) >>> 1 on both channels (one extra clock of latency).
module i2s_sample_rx #(
    parameter int unsigned WORD_BITS   = 18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    i2s_sample_rx_if.slave bus
);
    localparam int unsigned CntW = $clog2(WORD_BITS);

    typedef enum logic [1:0] {StIdle, StShift, StWait} state_e;

    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lr_sync, r_sd_sync;
    logic                   r_bclk_prev, r_lr_prev;
    state_e                 r_state, w_state_d;
    logic                   r_chan, w_chan_d;
    logic [CntW-1:0]        r_bitcnt, w_bitcnt_d;
    logic [WORD_BITS-1:0]   r_shreg, w_shreg_d;
    logic [WORD_BITS-1:0]   r_hold_l, w_hold_l_d, r_hold_r, w_hold_r_d;
    logic                   r_left_valid, w_left_valid_d;
    logic                   r_frame_err, w_frame_err_d;
    logic                   r_upd, w_upd_d;
    logic [WORD_BITS-1:0]   r_dataout_l, r_dataout_r;
    logic                   r_endata;

    logic                 w_tick, w_lr, w_sd, w_boundary;
    logic [WORD_BITS-1:0] w_word;

    assign w_tick     = ~r_bclk_prev & r_bclk_sync[SYNC_STAGES-1];
    assign w_lr       = r_lr_sync[SYNC_STAGES-1];
    assign w_sd       = r_sd_sync[SYNC_STAGES-1];
    assign w_boundary = w_tick && (w_lr != r_lr_prev);
    assign w_word     = {r_shreg[WORD_BITS-2:0], w_sd};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bclk_sync  <= '0;
            r_lr_sync    <= '0;
            r_sd_sync    <= '0;
            r_bclk_prev  <= 1'b0;
            r_lr_prev    <= 1'b0;
            r_state      <= StIdle;
            r_chan       <= 1'b0;
            r_bitcnt     <= '0;
            r_shreg      <= '0;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_left_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_upd        <= 1'b0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bus.bclk_in};
            r_lr_sync    <= {r_lr_sync[SYNC_STAGES-2:0], bus.lrclk_in};
            r_sd_sync    <= {r_sd_sync[SYNC_STAGES-2:0], bus.sdata_in};
            r_bclk_prev  <= r_bclk_sync[SYNC_STAGES-1];
            if (w_tick) r_lr_prev <= w_lr;
            r_state      <= w_state_d;
            r_chan       <= w_chan_d;
            r_bitcnt     <= w_bitcnt_d;
            r_shreg      <= w_shreg_d;
            r_hold_l     <= w_hold_l_d;
            r_hold_r     <= w_hold_r_d;
            r_left_valid <= w_left_valid_d;
            r_frame_err  <= w_frame_err_d;
            r_upd        <= w_upd_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_chan_d       = r_chan;
        w_bitcnt_d     = r_bitcnt;
        w_shreg_d      = r_shreg;
        w_hold_l_d     = r_hold_l;
        w_hold_r_d     = r_hold_r;
        w_left_valid_d = r_left_valid;
        w_frame_err_d  = r_frame_err;
        w_upd_d        = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                StIdle: begin
                    // Only a fall to left starts capture, so a partial first frame is dropped.
                    if (w_boundary && !w_lr) begin
                        w_state_d  = StShift;
                        w_chan_d   = 1'b0;
                        w_bitcnt_d = '0;
                        w_shreg_d  = '0;
                    end
                end
                StShift: begin
                    if (w_boundary) begin
                        w_frame_err_d  = 1'b1;
                        w_left_valid_d = 1'b0;
                        w_chan_d       = w_lr;
                        w_bitcnt_d     = '0;
                        w_shreg_d      = '0;
                    end else begin
                        w_shreg_d  = w_word;
                        w_bitcnt_d = r_bitcnt + 1'b1;
                        if (r_bitcnt == CntW'(WORD_BITS - 1)) begin
                            w_state_d = StWait;
                            if (!r_chan) begin
                                w_hold_l_d     = w_word;
                                w_left_valid_d = 1'b1;
                            end else begin
                                w_hold_r_d = w_word;
                                if (r_left_valid) begin
                                    w_upd_d        = 1'b1;
                                    w_left_valid_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                StWait: begin
                    if (w_boundary) begin
                        w_state_d  = StShift;
                        w_chan_d   = w_lr;
                        w_bitcnt_d = '0;
                        w_shreg_d  = '0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

`ifdef I2S_MONO_MIX_EN
    // floor((L+R)/2) = (L>>>1) + (R>>>1) + (L[0] & R[0]); cannot overflow 18 bits.
    logic [WORD_BITS-1:0] w_mix, r_mix;
    logic                 r_upd2;

    assign w_mix = {r_hold_l[WORD_BITS-1], r_hold_l[WORD_BITS-1:1]}
                 + {r_hold_r[WORD_BITS-1], r_hold_r[WORD_BITS-1:1]}
                 + {{(WORD_BITS-1){1'b0}}, r_hold_l[0] & r_hold_r[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mix       <= '0;
            r_upd2      <= 1'b0;
            r_dataout_l <= '0;
            r_dataout_r <= '0;
            r_endata    <= 1'b0;
        end else begin
            r_upd2   <= r_upd;
            r_endata <= r_upd2;
            if (r_upd) r_mix <= w_mix;
            if (r_upd2) begin
                r_dataout_l <= r_mix;
                r_dataout_r <= r_mix;
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dataout_l <= '0;
            r_dataout_r <= '0;
            r_endata    <= 1'b0;
        end else begin
            r_endata <= r_upd;
            if (r_upd) begin
                r_dataout_l <= r_hold_l;
                r_dataout_r <= r_hold_r;
            end
        end
    end
`endif

    assign bus.dataout_l = r_dataout_l;
    assign bus.dataout_r = r_dataout_r;
    assign bus.endata    = r_endata;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench for i2s_sample_rx: clock = 8x bclk, hand-built I2S frames; honours I2S_MONO_MIX_EN.
module tb_i2s_sample_rx;
    localparam int unsigned WordBits   = 18;
    localparam int unsigned SyncStages = 2;
`ifdef I2S_MONO_MIX_EN
    localparam int unsigned ExpLat = SyncStages + 3;
`else
    localparam int unsigned ExpLat = SyncStages + 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    i2s_sample_rx_if #(.WORD_BITS(WordBits)) bus ();

    i2s_sample_rx #(
        .WORD_BITS  (WordBits),
        .SYNC_STAGES(SyncStages)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0, mark_cyc = 0, strobe_cyc = 0;
    int unsigned n_strobe = 0, n_double = 0, base = 0;
    logic        prev_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.endata) begin
            n_strobe   = n_strobe + 1;
            strobe_cyc = cyc;
            if (prev_en) n_double = n_double + 1;
        end
        prev_en = bus.endata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] exp_l(input logic [17:0] l, input logic [17:0] r);
`ifdef I2S_MONO_MIX_EN
        logic signed [18:0] s;
        s = $signed({l[17], l}) + $signed({r[17], r});
        s = s >>> 1;
        return s[17:0];
`else
        if (r == 18'h0) return l;
        return l;
`endif
    endfunction

    function automatic logic [17:0] exp_r(input logic [17:0] l, input logic [17:0] r);
`ifdef I2S_MONO_MIX_EN
        return exp_l(l, r);
`else
        if (l == 18'h0) return r;
        return r;
`endif
    endfunction

    // Data and word select change on the bclk falling edge; each bit is 8 system clocks.
    task automatic send_bit(input logic lr, input logic d, input logic mark);
        bus.bclk_in  = 1'b0;
        bus.lrclk_in = lr;
        bus.sdata_in = d;
        repeat (4) @(negedge clock);
        bus.bclk_in = 1'b1;
        if (mark) mark_cyc = cyc;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_slot(input logic lr, input logic [17:0] w, input int nbits);
        logic d;
        for (int i = 0; i < nbits; i++) begin
            d = 1'b0;
            if (i >= 1 && i <= WordBits) d = w[WordBits-i];
            send_bit(lr, d, lr && (i == WordBits));
        end
    endtask

    task automatic send_frame(input logic [17:0] l, input logic [17:0] r, input int nbits);
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
        repeat (10) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset        = 1'b1;
        bus.bclk_in  = 1'b0;
        bus.sdata_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        base  = n_strobe;
    endtask

    task automatic check_pair(input string tag, input logic [17:0] l, input logic [17:0] r);
        check_eq({tag, "_l"}, 32'(bus.dataout_l), 32'(exp_l(l, r)));
        check_eq({tag, "_r"}, 32'(bus.dataout_r), 32'(exp_r(l, r)));
    endtask

    initial begin
        bus.bclk_in  = 1'b0;
        bus.lrclk_in = 1'b1;
        bus.sdata_in = 1'b0;
        apply_reset();

        check_eq("rst_l", 32'(bus.dataout_l), 32'h0);
        check_eq("rst_r", 32'(bus.dataout_r), 32'h0);
        check_eq("rst_en", 32'(bus.endata), 32'h0);
        check_eq("rst_err", 32'(bus.frame_err), 32'h0);

        // Basic frames, 32 bclk per slot, preceded by a right lead-in.
        send_slot(1'b1, 18'h0, 32);
        send_slot(1'b0, 18'h2AAAA, 32);
        check_eq("basic_no_early", n_strobe - base, 0);
        send_slot(1'b1, 18'h15555, 32);
        repeat (10) @(negedge clock);
        check_eq("basic_one", n_strobe - base, 1);
        check_pair("basic1", 18'h2AAAA, 18'h15555);
        check_eq("basic_lat", strobe_cyc - mark_cyc, ExpLat);
        send_frame(18'h2AAAA, 18'h15555, 32);
        check_eq("basic_two", n_strobe - base, 2);
        check_pair("basic2", 18'h2AAAA, 18'h15555);
        check_eq("basic_err", 32'(bus.frame_err), 32'h0);

        // Stream begins partway through a right slot.
        apply_reset();
        send_slot(1'b1, 18'h3FFFF, 12);
        send_slot(1'b0, 18'h12345, 32);
        check_eq("mid_no_early", n_strobe - base, 0);
        send_slot(1'b1, 18'h0ABCD, 32);
        repeat (10) @(negedge clock);
        check_eq("mid_one", n_strobe - base, 1);
        check_pair("mid", 18'h12345, 18'h0ABCD);

        // Truncated left slot.
        apply_reset();
        send_slot(1'b1, 18'h0, 32);
        send_slot(1'b0, 18'h2AAAA, 10);
        send_slot(1'b1, 18'h15555, 32);
        repeat (10) @(negedge clock);
        check_eq("short_err", 32'(bus.frame_err), 32'h1);
        check_eq("short_none", n_strobe - base, 0);
        check_pair("short_hold", 18'h0, 18'h0);
        send_frame(18'h00001, 18'h3FFFF, 32);
        check_eq("short_next", n_strobe - base, 1);
        check_pair("short_next", 18'h00001, 18'h3FFFF);
        check_eq("short_sticky", 32'(bus.frame_err), 32'h1);

        // Reset during the 9th data bit of a right word.
        apply_reset();
        send_slot(1'b1, 18'h0, 32);
        send_frame(18'h1F00F, 18'h0F0F1, 32);
        check_pair("pre_rst", 18'h1F00F, 18'h0F0F1);
        send_slot(1'b0, 18'h2AAAA, 32);
        send_slot(1'b1, 18'h15555, 9);
        bus.bclk_in  = 1'b0;
        bus.sdata_in = 1'b1;
        repeat (4) @(negedge clock);
        bus.bclk_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_l", 32'(bus.dataout_l), 32'h0);
        check_eq("midrst_r", 32'(bus.dataout_r), 32'h0);
        check_eq("midrst_en", 32'(bus.endata), 32'h0);
        reset = 1'b0;
        base  = n_strobe;
        repeat (2) @(negedge clock);
        send_slot(1'b1, 18'h0, 23);
        repeat (10) @(negedge clock);
        check_eq("midrst_none", n_strobe - base, 0);
        send_frame(18'h00F0F, 18'h30303, 32);
        check_eq("midrst_resume", n_strobe - base, 1);
        check_pair("midrst_resume", 18'h00F0F, 18'h30303);

        // 19-bclk slots: delay bit plus exactly 18 data bits.
        apply_reset();
        send_slot(1'b1, 18'h0, 32);
        send_frame(18'h0F0F0, 18'h30303, 19);
        check_pair("tight1", 18'h0F0F0, 18'h30303);
        check_eq("tight_lat", strobe_cyc - mark_cyc, ExpLat);
        send_frame(18'h20001, 18'h1FFFE, 19);
        check_pair("tight2", 18'h20001, 18'h1FFFE);
        check_eq("tight_cnt", n_strobe - base, 2);
        check_eq("tight_err", 32'(bus.frame_err), 32'h0);

        check_eq("no_double_strobe", n_double, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
